// File: rtl/tqvp_byte_pwm.sv
// tqvp_byte_pwm: multi-channel 8-bit PWM for the TinyQV byte-peripheral slot
module tqvp_byte_pwm #(
    parameter int NUM_CH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    logic [2:0] ctrl_q, ctrl_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] period_q, period_d;
    logic [7:0] period_act_q, period_act_d;
    logic [7:0] presc_cnt_q, presc_cnt_d;
    logic [7:0] count_q, count_d;
    logic       wrap_q, wrap_d;
    logic [7:0] duty_q [NUM_CH];
    logic [7:0] duty_d [NUM_CH];
    logic [7:0] duty_act_q [NUM_CH];
    logic [7:0] duty_act_d [NUM_CH];
    logic       en, tick, wrap_now, load;
    logic       unused_ui;

    assign en        = ctrl_q[0];
    assign unused_ui = ^ui_in;

    // Bus writes to pending registers, prescaler/period counting and active-copy reload
    always_comb begin
        ctrl_d      = (data_write && address == 4'h0) ? data_in[2:0] : ctrl_q;
        presc_d     = (data_write && address == 4'h1) ? data_in : presc_q;
        period_d    = (data_write && address == 4'h2) ? data_in : period_q;
        tick        = en && (presc_cnt_q >= presc_q);
        wrap_now    = tick && (count_q >= period_act_q);
        load        = !en || wrap_now;
        presc_cnt_d = (!en || tick) ? 8'h00 : presc_cnt_q + 8'h01;
        count_d     = !en ? 8'h00 : !tick ? count_q : wrap_now ? 8'h00 : count_q + 8'h01;
        period_act_d = load ? period_q : period_act_q;
        wrap_d      = wrap_now || (wrap_q && !(data_write && address == 4'h3 && data_in[0]));
        for (int i = 0; i < NUM_CH; i++) begin
            duty_d[i]     = (data_write && address == 4'(8 + i)) ? data_in : duty_q[i];
            duty_act_d[i] = load ? duty_q[i] : duty_act_q[i];
        end
    end

    // Register state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q       <= 3'b000;
            presc_q      <= 8'h00;
            period_q     <= 8'h00;
            period_act_q <= 8'h00;
            presc_cnt_q  <= 8'h00;
            count_q      <= 8'h00;
            wrap_q       <= 1'b0;
            duty_q       <= '{default: 8'h00};
            duty_act_q   <= '{default: 8'h00};
        end else begin
            ctrl_q       <= ctrl_d;
            presc_q      <= presc_d;
            period_q     <= period_d;
            period_act_q <= period_act_d;
            presc_cnt_q  <= presc_cnt_d;
            count_q      <= count_d;
            wrap_q       <= wrap_d;
            duty_q       <= duty_d;
            duty_act_q   <= duty_act_d;
        end
    end

    // Register read mux; unmapped and absent duty channels read 0
    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0:    data_out = {5'b00000, ctrl_q};
            4'h1:    data_out = presc_q;
            4'h2:    data_out = period_q;
            4'h3:    data_out = {7'b0000000, wrap_q};
            4'h4:    data_out = count_q;
            default: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (address == 4'(8 + i)) data_out = duty_q[i];
            end
        endcase
    end

    for (genvar i = 0; i < 8; i++) begin : g_out
        if (i < NUM_CH) begin : g_pwm
            assign uo_out[i] = (en && (count_q < duty_act_q[i])) ^ ctrl_q[1];
        end else begin : g_pass
            assign uo_out[i] = ctrl_q[2] & ui_in[i];
        end
    end
endmodule
